// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, channel
// indices and the default start-handshake timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_POP,
    ARB_WAIT_DATA,
    ARB_START,
    ARB_WAIT_DONE
  } arb_state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned START_TO_DEFAULT = 255;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return (ch == CH1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way selector: fixed priority (ch0 first) or round-robin
// against the last-served channel.
module rr_pick2
  import uart_pkg::*;
(
  input  logic empty0,
  input  logic empty1,
  input  logic last,
  input  logic prio_mode,
  output logic winner,
  output logic any
);

  always_comb begin
    any    = !empty0 || !empty1;
    winner = CH0;
    if (prio_mode || last == CH1) begin
      winner = empty0 ? CH1 : CH0;
    end else begin
      winner = empty1 ? CH0 : CH1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between two byte FIFOs: pops one byte from the
// granted FIFO, runs the start/busy/done handshake, then re-arbitrates.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned START_TO = START_TO_DEFAULT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             prio_mode,
  input  logic             empty0,
  input  logic [7:0]       data0,
  output logic             rd_en0,
  input  logic             empty1,
  input  logic [7:0]       data1,
  output logic             rd_en1,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             timeout_err
);

  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
  localparam int unsigned TMR_W = $clog2(START_TO + 1);

  arb_state_t       state, state_nxt;
  logic             owner, owner_nxt;
  logic             last, last_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;

  logic             rd_en0_nxt, rd_en1_nxt;
  logic [7:0]       tx_data_nxt;
  logic             tx_start_nxt;
  logic [1:0]       grant_nxt;
  logic             busy_nxt;
  logic [CNT_W-1:0] cnt0_nxt, cnt1_nxt;
  logic             timeout_err_nxt;

  logic             pick_winner;
  logic             pick_any;

  rr_pick2 u_pick (
    .empty0    (empty0),
    .empty1    (empty1),
    .last      (last),
    .prio_mode (prio_mode),
    .winner    (pick_winner),
    .any       (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      owner       <= CH0;
      last        <= CH1;
      lat_cnt     <= '0;
      tmr         <= '0;
      rd_en0      <= 1'b0;
      rd_en1      <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant       <= '0;
      busy        <= 1'b0;
      cnt0        <= '0;
      cnt1        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last        <= last_nxt;
      lat_cnt     <= lat_cnt_nxt;
      tmr         <= tmr_nxt;
      rd_en0      <= rd_en0_nxt;
      rd_en1      <= rd_en1_nxt;
      tx_data     <= tx_data_nxt;
      tx_start    <= tx_start_nxt;
      grant       <= grant_nxt;
      busy        <= busy_nxt;
      cnt0        <= cnt0_nxt;
      cnt1        <= cnt1_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Every output is computed one state ahead so it can be registered;
  // rd_en is raised on the IDLE->POP transition and therefore lives in POP only.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_nxt        = last;
    lat_cnt_nxt     = lat_cnt;
    tmr_nxt         = tmr;
    rd_en0_nxt      = 1'b0;
    rd_en1_nxt      = 1'b0;
    tx_data_nxt     = tx_data;
    tx_start_nxt    = tx_start;
    grant_nxt       = grant;
    cnt0_nxt        = cnt0;
    cnt1_nxt        = cnt1;
    timeout_err_nxt = timeout_err;

    unique case (state)
      ARB_IDLE: begin
        if (en && pick_any) begin
          owner_nxt  = pick_winner;
          grant_nxt  = ch_onehot(pick_winner);
          rd_en0_nxt = (pick_winner == CH0);
          rd_en1_nxt = (pick_winner == CH1);
          state_nxt  = ARB_POP;
        end
      end

      ARB_POP: begin
        lat_cnt_nxt = '0;
        state_nxt   = ARB_WAIT_DATA;
      end

      ARB_WAIT_DATA: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          tx_data_nxt  = (owner == CH1) ? data1 : data0;
          tx_start_nxt = 1'b1;
          tmr_nxt      = '0;
          state_nxt    = ARB_START;
        end else begin
          lat_cnt_nxt = lat_cnt + LAT_W'(1);
        end
      end

      ARB_START, ARB_WAIT_DONE: begin
        if (tx_done) begin
          tx_start_nxt = 1'b0;
          last_nxt     = owner;
          grant_nxt    = '0;
          state_nxt    = ARB_IDLE;
          if (owner == CH1) cnt1_nxt = cnt1 + CNT_W'(1);
          else              cnt0_nxt = cnt0 + CNT_W'(1);
        end else if (state == ARB_START) begin
          if (tx_busy) begin
            tx_start_nxt = 1'b0;
            state_nxt    = ARB_WAIT_DONE;
          end else if (tmr == TMR_W'(START_TO - 1)) begin
            tx_start_nxt    = 1'b0;
            timeout_err_nxt = 1'b1;
            grant_nxt       = '0;
            state_nxt       = ARB_IDLE;
          end else begin
            tmr_nxt = tmr + TMR_W'(1);
          end
        end
      end

      default: begin
        tx_start_nxt = 1'b0;
        grant_nxt    = '0;
        state_nxt    = ARB_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ARB_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and sender models, directed scenario table,
// hand-written corner cases and randomized runs against an ordering model.
module tb_uart_tx_arbiter;

  localparam int RD_LAT   = 2;
  localparam int START_TO = 20;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             prio_mode = 1'b0;
  logic             empty0, empty1;
  logic [7:0]       data0, data1;
  logic             rd_en0, rd_en1;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done = 1'b0;
  logic [1:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .RD_LAT   (RD_LAT),
    .START_TO (START_TO),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .prio_mode   (prio_mode),
    .empty0      (empty0),
    .data0       (data0),
    .rd_en0      (rd_en0),
    .empty1      (empty1),
    .data1       (data1),
    .rd_en1      (rd_en1),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant       (grant),
    .busy        (busy),
    .cnt0        (cnt0),
    .cnt1        (cnt1),
    .timeout_err (timeout_err)
  );

  // FIFO models with RD_LAT cycles of read latency
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int         wr0 = 0, wr1 = 0;
  int         rd0 = 0, rd1 = 0;
  logic [7:0] pipe0 [RD_LAT];
  logic [7:0] pipe1 [RD_LAT];

  assign empty0 = (rd0 == wr0);
  assign empty1 = (rd1 == wr1);
  assign data0  = pipe0[RD_LAT-1];
  assign data1  = pipe1[RD_LAT-1];

  always @(posedge clk) begin
    if (rd_en0) begin
      pipe0[0] <= mem0[rd0 % 64];
      rd0      <= rd0 + 1;
    end
    if (rd_en1) begin
      pipe1[0] <= mem1[rd1 % 64];
      rd1      <= rd1 + 1;
    end
    for (int k = 1; k < RD_LAT; k++) begin
      pipe0[k] <= pipe0[k-1];
      pipe1[k] <= pipe1[k-1];
    end
  end

  task automatic push0(input logic [7:0] b);
    mem0[wr0 % 64] = b;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1 % 64] = b;
    wr1 = wr1 + 1;
  endtask

  // Sender model: accepts on tx_start, stays busy a random length, pulses done.
  // Length 0 raises busy and done together.
  logic       s_busy = 1'b0;
  int         s_cnt = 0;
  int         s_len;
  bit         never_busy = 1'b0;
  int         busy_min = 10, busy_max = 10;
  logic [7:0] sent_b [$];
  logic [1:0] sent_g [$];

  assign tx_busy = s_busy;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (s_busy) begin
      if (s_cnt == 0) begin
        s_busy <= 1'b0;
      end else if (s_cnt == 1) begin
        s_busy  <= 1'b0;
        tx_done <= 1'b1;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end else if (tx_start && !never_busy) begin
      s_len = $urandom_range(busy_max, busy_min);
      sent_b.push_back(tx_data);
      sent_g.push_back(grant);
      s_busy <= 1'b1;
      s_cnt  <= s_len;
      if (s_len == 0) tx_done <= 1'b1;
    end
  end

  // Pop-strobe monitor
  int pops0 = 0, pops1 = 0, bad_pop = 0, long_pop = 0;
  bit prev_rd0 = 1'b0, prev_rd1 = 1'b0;

  always @(negedge clk) begin
    if (rd_en0 && rd_en1) bad_pop++;
    if ((rd_en0 || rd_en1) && !busy) bad_pop++;
    if ((rd_en0 && prev_rd0) || (rd_en1 && prev_rd1)) long_pop++;
    if (rd_en0) pops0++;
    if (rd_en1) pops1++;
    prev_rd0 = rd_en0;
    prev_rd1 = rd_en1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference ordering model
  logic [7:0] m0 [$];
  logic [7:0] m1 [$];
  bit         exp_ch [$];
  logic [7:0] exp_b [$];
  bit         model_last = 1'b1;
  int         exp_cnt0 = 0, exp_cnt1 = 0;

  function automatic void model_run(input bit prio);
    int i0, i1;
    bit pick;
    i0 = 0;
    i1 = 0;
    while (i0 < m0.size() || i1 < m1.size()) begin
      if (i0 >= m0.size())      pick = 1'b1;
      else if (i1 >= m1.size()) pick = 1'b0;
      else if (prio)            pick = 1'b0;
      else                      pick = !model_last;
      exp_ch.push_back(pick);
      if (pick) begin exp_b.push_back(m1[i1]); i1++; end
      else      begin exp_b.push_back(m0[i0]); i0++; end
      model_last = pick;
    end
  endfunction

  task automatic do_reset();
    en    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    exp_cnt0   = 0;
    exp_cnt1   = 0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  // Loads m0/m1, runs until the expected transfers drain, compares the log
  task automatic play(input bit prio, input string tag);
    int base, n, p0, p1, n0, n1, k;
    bit done;
    base = sent_b.size();
    n    = exp_b.size();
    p0   = pops0;
    p1   = pops1;
    n0   = m0.size();
    n1   = m1.size();
    en   = 1'b0;
    foreach (m0[i]) push0(m0[i]);
    foreach (m1[i]) push1(m1[i]);
    prio_mode = prio;
    @(negedge clk);
    en   = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (sent_b.size() >= base + n && !busy) begin
        done = 1'b1;
        break;
      end
    end
    en = 1'b0;
    check({tag, " drain"}, 32'(done), 32'd1);
    for (int i = 0; i < n; i++) begin
      k = base + i;
      check($sformatf("%s xfer%0d", tag, i),
            (k < sent_b.size()) ? {22'd0, sent_g[k], sent_b[k]} : 32'hFFFF_FFFF,
            {22'd0, (exp_ch[i] ? 2'b10 : 2'b01), exp_b[i]});
      if (exp_ch[i]) exp_cnt1++;
      else           exp_cnt0++;
    end
    check({tag, " cnt0"}, 32'(cnt0), 32'(exp_cnt0 % 256));
    check({tag, " cnt1"}, 32'(cnt1), 32'(exp_cnt1 % 256));
    check({tag, " pops0"}, 32'(pops0 - p0), 32'(n0));
    check({tag, " pops1"}, 32'(pops1 - p1), 32'(n1));
    m0.delete();
    m1.delete();
    exp_ch.delete();
    exp_b.delete();
  endtask

  typedef struct {
    bit         prio;
    int         n0;
    int         n1;
    logic [7:0] base0;
    logic [7:0] base1;
    logic [15:0] seq;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   i0, i1, mark, nhi;
    bit   seen;
    logic [31:0] outs;

    // channel order of sent bytes, bit i = channel of the i-th byte
    vecs[0] = '{1'b0, 2, 0, 8'h41, 8'h00, 16'h0000};
    vecs[1] = '{1'b0, 3, 3, 8'hA0, 8'hB0, 16'h002A};
    vecs[2] = '{1'b1, 3, 3, 8'hA0, 8'hB0, 16'h0038};
    vecs[3] = '{1'b0, 0, 2, 8'h00, 8'hC0, 16'h0003};
    vecs[4] = '{1'b0, 1, 3, 8'h10, 8'h20, 16'h000E};
    vecs[5] = '{1'b1, 2, 1, 8'h30, 8'h40, 16'h0004};

    repeat (2) @(negedge clk);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset rd_en", {30'd0, rd_en1, rd_en0}, 32'd0);
    check("reset grant", 32'(grant), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'd0);
    check("reset counters", {cnt1, cnt0}, 32'd0);
    check("reset timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      do_reset();
      i0 = 0;
      i1 = 0;
      for (int k = 0; k < vecs[v].n0; k++) m0.push_back(vecs[v].base0 + 8'(k));
      for (int k = 0; k < vecs[v].n1; k++) m1.push_back(vecs[v].base1 + 8'(k));
      for (int k = 0; k < vecs[v].n0 + vecs[v].n1; k++) begin
        exp_ch.push_back(vecs[v].seq[k]);
        if (vecs[v].seq[k]) begin exp_b.push_back(vecs[v].base1 + 8'(i1)); i1++; end
        else                begin exp_b.push_back(vecs[v].base0 + 8'(i0)); i0++; end
      end
      play(vecs[v].prio, $sformatf("vec%0d", v));
    end

    // Start handshake timeout
    do_reset();
    never_busy = 1'b1;
    push0(8'h61);
    push0(8'h62);
    prio_mode = 1'b0;
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    check("timeout start seen", 32'(seen), 32'd1);
    nhi = 0;
    while (tx_start && nhi < 200) begin
      nhi++;
      @(negedge clk);
    end
    check("timeout start width", nhi, START_TO);
    check("timeout err set", 32'(timeout_err), 32'd1);
    check("timeout grant cleared", 32'(grant), 32'd0);
    check("timeout cnt0", 32'(cnt0), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rd_en0) seen = 1'b1;
    end
    check("timeout next pop", 32'(seen), 32'd1);
    never_busy = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (cnt0 == 8'd1 && !busy) seen = 1'b1;
    end
    check("timeout recovery cnt0", 32'(cnt0), 32'd1);
    check("timeout err sticky", 32'(timeout_err), 32'd1);
    check("timeout recovery byte", 32'(sent_b[$]), 32'h62);

    // en dropped while a byte is in flight
    do_reset();
    push0(8'h71);
    push0(8'h72);
    push0(8'h73);
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (tx_busy) seen = 1'b1;
    end
    check("en_low sender busy", 32'(seen), 32'd1);
    @(negedge clk);
    en   = 1'b0;
    mark = pops0;
    repeat (40) @(negedge clk);
    check("en_low byte completes", 32'(cnt0), 32'd1);
    check("en_low no pop", pops0 - mark, 0);
    check("en_low idle", {30'd0, busy, |grant}, 32'd0);
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (cnt0 == 8'd3 && !busy) seen = 1'b1;
    end
    en = 1'b0;
    check("en_low resume cnt0", 32'(cnt0), 32'd3);
    check("en_low bytes", {8'd0, sent_b[$-2], sent_b[$-1], sent_b[$]}, 32'h0071_7273);

    // Asynchronous reset while tx_start is held
    do_reset();
    never_busy = 1'b1;
    push0(8'h10);
    push0(8'h11);
    push1(8'h20);
    prio_mode = 1'b0;
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    check("reset_mid start seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {tx_start, rd_en0, rd_en1, grant, busy, timeout_err, tx_data, cnt0, cnt1[0]};
    check("reset_mid outputs", outs, 32'd0);
    check("reset_mid cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n      = 1'b1;
    never_busy = 1'b0;
    exp_cnt0   = 0;
    exp_cnt1   = 0;
    model_last = 1'b1;
    check("reset_mid no start glitch", 32'(tx_start), 32'd0);
    exp_ch.push_back(1'b0); exp_b.push_back(8'h11);
    exp_ch.push_back(1'b1); exp_b.push_back(8'h20);
    mark = sent_b.size();
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (sent_b.size() >= mark + 2 && !busy) seen = 1'b1;
    end
    en = 1'b0;
    check("reset_mid drain", 32'(seen), 32'd1);
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_mid xfer%0d", i),
            (mark + i < sent_b.size()) ? {22'd0, sent_g[mark+i], sent_b[mark+i]} : 32'hFFFF_FFFF,
            {22'd0, (exp_ch[i] ? 2'b10 : 2'b01), exp_b[i]});
    check("reset_mid counters", {cnt1, cnt0}, {16'd0, 8'd1, 8'd1});
    exp_ch.delete();
    exp_b.delete();

    // Randomized runs; last-served state carries over between runs
    do_reset();
    busy_min = 0;
    busy_max = 12;
    for (int r = 0; r < 10; r++) begin
      bit prio;
      int n0, n1;
      prio = 1'($urandom_range(0, 1));
      n0   = $urandom_range(0, 5);
      n1   = $urandom_range(0, 5);
      for (int k = 0; k < n0; k++) m0.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < n1; k++) m1.push_back(8'($urandom_range(0, 255)));
      model_run(prio);
      play(prio, $sformatf("rand%0d", r));
    end

    check("rd_en exclusive and in POP only", bad_pop, 0);
    check("rd_en single-cycle", long_pop, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
